// File: rtl/pow2_pkg.sv
// Shared constants and FSM state type for the 2^k FP32 scheduler.
// Optional signed exponent input is enabled by POW2_NEG_EXP_EN.
package pow2_pkg;

    localparam int          FP32_BIAS    = 127;
    localparam logic [31:0] FP32_ONE     = 32'h3F80_0000;
    localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } pow2_state_t;

endpackage

// File: rtl/pow2_exp_unit.sv
// Combinational k -> FP32 2^k encoder with +Inf saturation.
// POW2_NEG_EXP_EN: k is two's complement and underflow flushes to zero.
module pow2_exp_unit
    import pow2_pkg::*;
#(
    parameter int EXP_W = 8
) (
    input  logic [EXP_W-1:0] k,
    output logic [31:0]      fp
);

    // Wide enough that k + bias never wraps, even for tiny EXP_W
    localparam int EW = (EXP_W + 2 > 10) ? EXP_W + 2 : 10;

    logic signed [EW-1:0] e;
    logic                 ovf;
    logic                 unf;

    always_comb begin
`ifdef POW2_NEG_EXP_EN
        e   = EW'($signed(k)) + EW'(FP32_BIAS);
        unf = (e < 1);
`else
        e   = $signed(EW'(k)) + EW'(FP32_BIAS);
        unf = 1'b0;
`endif
        ovf = (e >= 255);
        fp  = FP32_ZERO;
        unique case (1'b1)
            ovf:     fp = FP32_POS_INF;
            unf:     fp = FP32_ZERO;
            default: fp = {1'b0, e[7:0], 23'd0};
        endcase
    end

endmodule

// File: rtl/pow2_int_scheduler.sv
// Round-robin scheduler sharing one 2^k encoder among N_REQ requesters.
// Build option POW2_NEG_EXP_EN selects signed exponents (see pow2_exp_unit).
module pow2_int_scheduler
    import pow2_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int EXP_W = 8,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*EXP_W-1:0] req_exp,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_data,
    output logic [IDW-1:0]     rsp_id,
    output logic               busy
);

    pow2_state_t      state;
    pow2_state_t      state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   id_q;
    logic [EXP_W-1:0] k_q;
    logic             grant_vld;
    logic [IDW-1:0]   grant_id;
    logic [31:0]      enc;

    // First valid requester at or after rr_ptr, wrapping
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        unique case (state)
            IDLE: begin
                if (grant_vld) begin
                    req_ready[grant_id] = 1'b1;
                    state_nxt           = CALC;
                end
            end
            CALC: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    pow2_exp_unit #(
        .EXP_W (EXP_W)
    ) u_exp (
        .k  (k_q),
        .fp (enc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            id_q     <= '0;
            k_q      <= '0;
            rsp_data <= FP32_ZERO;
            rsp_id   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_vld) begin
                k_q    <= req_exp[grant_id*EXP_W +: EXP_W];
                id_q   <= grant_id;
                rr_ptr <= (grant_id == IDW'(N_REQ - 1)) ? '0
                                                         : grant_id + 1'b1;
            end
            if (state == CALC) begin
                rsp_data <= enc;
                rsp_id   <= id_q;
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule
